// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: sequences I2C slave byte events into register-block
// pointer loads, auto-incrementing writes and auto-incrementing reads.
// Optional feature macro: REG_RO_PROTECT_EN (drops writes at ptr >= RO_BASE).
module reg_access_ctrl #(
    parameter logic [7:0] RO_BASE = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_start,
    input  logic       i2c_rw,
    input  logic       i2c_stop,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_req,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       we,
    output logic [7:0] Adr_wr,
    output logic [7:0] DI,
    output logic [7:0] Adr_rd,
    input  logic [7:0] dat_REG,
    output logic       busy,
    output logic       ro_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PTR   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] ptr;

    // Data events only act when no START/STOP claims the cycle
    logic ctrl_evt_c;
    logic ld_ok_c;
    logic wr_ok_c;
    logic rd_ok_c;
    logic ro_hit_c;

    assign ctrl_evt_c = i2c_start | i2c_stop;
    assign ld_ok_c    = rx_valid & ~ctrl_evt_c & (state == PTR);
    assign wr_ok_c    = rx_valid & ~ctrl_evt_c & (state == WRITE);
    assign rd_ok_c    = tx_req   & ~ctrl_evt_c & (state == READ);

`ifdef REG_RO_PROTECT_EN
    // Bytes aimed at the read-only window are dropped
    assign ro_hit_c = (ptr >= RO_BASE);
`else
    logic unused_ro_base;
    assign unused_ro_base = ^RO_BASE;
    assign ro_hit_c       = 1'b0;
`endif

    // Read address always tracks the pointer
    assign Adr_rd = ptr;

    // FSM, pointer and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 8'h00;
            we       <= 1'b0;
            Adr_wr   <= 8'h00;
            DI       <= 8'h00;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            ro_err   <= 1'b0;
        end else begin
            we       <= 1'b0;
            tx_valid <= 1'b0;
            ro_err   <= 1'b0;

            if (i2c_start) begin
                state <= i2c_rw ? READ : PTR;
                busy  <= 1'b1;
            end else if (i2c_stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (ld_ok_c) begin
                state <= WRITE;
            end

            if (ld_ok_c) begin
                ptr <= rx_data;
            end

            if (wr_ok_c) begin
                ptr <= ptr + 8'd1;
                if (ro_hit_c) begin
                    ro_err <= 1'b1;
                end else begin
                    we     <= 1'b1;
                    Adr_wr <= ptr;
                    DI     <= rx_data;
                end
            end

            // Every tx_req is answered; only a READ-state request consumes data
            if (tx_req) begin
                tx_valid <= 1'b1;
                tx_data  <= rd_ok_c ? dat_REG : 8'hFF;
            end
            if (rd_ok_c) begin
                ptr <= ptr + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Scoreboard bench for reg_access_ctrl with a behavioural 256x8 register block.
module tb_reg_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i2c_start, i2c_rw, i2c_stop;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_req;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       we;
    logic [7:0] Adr_wr, DI, Adr_rd, dat_REG;
    logic       busy, ro_err;

    reg_access_ctrl dut (
        .clk(clk), .rst(rst),
        .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_stop(i2c_stop),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_req(tx_req), .tx_valid(tx_valid), .tx_data(tx_data),
        .we(we), .Adr_wr(Adr_wr), .DI(DI), .Adr_rd(Adr_rd),
        .dat_REG(dat_REG), .busy(busy), .ro_err(ro_err)
    );

    always #5 clk = ~clk;

    // Register block model: synchronous write, asynchronous read
    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    always @(posedge clk) if (we) mem[Adr_wr] <= DI;
    assign dat_REG = mem[Adr_rd];

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wq[$];
    logic [7:0] exp_rq[$];
    int         exp_ro = 0;
    int         n_cmp  = 0;
    int         n_bad  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit is_ro(logic [7:0] a);
`ifdef REG_RO_PROTECT_EN
        return a >= 8'hF0;
`else
        return (a == a) ? 1'b0 : 1'b0;
`endif
    endfunction

    // Expect a written byte at address a: either a we pulse or a protection drop
    task automatic expect_wr(logic [7:0] a, logic [7:0] d);
        if (is_ro(a)) exp_ro++;
        else exp_wq.push_back('{a: a, d: d});
    endtask

    // Monitor: pops expectations whenever the DUT presents an output strobe
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_wq.size() == 0) check("unexpected_we", {16'h0, Adr_wr, DI}, 32'hFFFF_FFFF);
            else begin
                wr_t e;
                e = exp_wq.pop_front();
                check("write_addr_data", {16'h0, Adr_wr, DI}, {16'h0, e.a, e.d});
            end
        end
        if (tx_valid === 1'b1) begin
            if (exp_rq.size() == 0) check("unexpected_tx_valid", {24'h0, tx_data}, 32'hFFFF_FFFF);
            else check("tx_data", {24'h0, tx_data}, {24'h0, exp_rq.pop_front()});
        end
        if (ro_err === 1'b1) begin
            if (exp_ro == 0) check("unexpected_ro_err", 32'd1, 32'd0);
            else begin
                exp_ro--;
                n_cmp++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(logic rw);
        i2c_start = 1'b1; i2c_rw = rw;
        tick();
        i2c_start = 1'b0;
    endtask

    task automatic do_stop();
        i2c_stop = 1'b1;
        tick();
        i2c_stop = 1'b0;
    endtask

    task automatic do_rx(logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_txr();
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i2c_start = 1'b0; i2c_rw = 1'b0; i2c_stop = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; tx_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_ptr", {24'h0, Adr_rd}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_outs", {14'h0, we, tx_valid, ro_err, tx_data, Adr_wr}, 32'h0);

        // Write burst
        do_start(1'b0);
        check("busy_after_start", {31'h0, busy}, 32'h1);
        do_rx(8'h10);
        check("ptr_load", {24'h0, Adr_rd}, 32'h10);
        expect_wr(8'h10, 8'hA1);
        do_rx(8'hA1);
        check("ptr_inc_with_we", {25'h0, we, Adr_rd}, {25'h0, 1'b1, 8'h11});
        expect_wr(8'h11, 8'hA2);
        do_rx(8'hA2);
        do_stop();
        check("burst_ptr", {24'h0, Adr_rd}, 32'h12);
        check("busy_after_stop", {31'h0, busy}, 32'h0);

        // Read with repeated START
        do_start(1'b0);
        do_rx(8'h10);
        do_start(1'b1);
        exp_rq.push_back(8'hA1);
        do_txr();
        check("tx_valid_latency", {31'h0, tx_valid}, 32'h1);
        tick();
        check("tx_valid_one_cycle", {31'h0, tx_valid}, 32'h0);
        exp_rq.push_back(8'hA2);
        do_txr();
        check("read_ptr", {24'h0, Adr_rd}, 32'h12);
        do_stop();

        // Wrap-around
        do_start(1'b0);
        do_rx(8'hFE);
        expect_wr(8'hFE, 8'h11);
        do_rx(8'h11);
        expect_wr(8'hFF, 8'h22);
        do_rx(8'h22);
        expect_wr(8'h00, 8'h33);
        do_rx(8'h33);
        do_stop();
        check("wrap_ptr", {24'h0, Adr_rd}, 32'h01);

        // START and STOP in the same cycle: START wins
        i2c_start = 1'b1; i2c_rw = 1'b0; i2c_stop = 1'b1;
        tick();
        i2c_start = 1'b0; i2c_stop = 1'b0;
        check("start_beats_stop", {31'h0, busy}, 32'h1);
        do_rx(8'h55);
        check("ptr_state_entered", {24'h0, Adr_rd}, 32'h55);
        do_start(1'b1);
        do_rx(8'h77);
        check("rx_in_read_ignored", {24'h0, Adr_rd}, 32'h55);
        do_stop();
        exp_rq.push_back(8'hFF);
        do_txr();
        check("idle_txreq_ptr", {24'h0, Adr_rd}, 32'h55);

        // Reset mid-burst: in-flight write lands
        do_start(1'b0);
        do_rx(8'h20);
        expect_wr(8'h20, 8'hC4);
        do_rx(8'hC4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_ptr", {24'h0, Adr_rd}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_outs", {6'h0, we, tx_valid, ro_err, tx_data, Adr_wr, DI}, 32'h0);
        do_start(1'b0);
        do_rx(8'h20);
        do_start(1'b1);
        exp_rq.push_back(8'hC4);
        do_txr();
        check("rst_write_landed_ptr", {24'h0, Adr_rd}, 32'h21);
        do_stop();

`ifdef REG_RO_PROTECT_EN
        // Read-only boundary
        do_start(1'b0);
        do_rx(8'hEF);
        expect_wr(8'hEF, 8'h5A);
        do_rx(8'h5A);
        expect_wr(8'hF0, 8'h6B);
        do_rx(8'h6B);
        check("ro_err_pulse", {31'h0, ro_err}, 32'h1);
        check("ro_ptr", {24'h0, Adr_rd}, 32'hF1);
        do_stop();
`endif

        tick(); tick();
        check("write_queue_drained", exp_wq.size(), 32'd0);
        check("read_queue_drained", exp_rq.size(), 32'd0);
        check("ro_expect_drained", exp_ro, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
